// File: rtl/block_ram_responder.sv
// Dual-port line-oriented block RAM for a CPU memory subsystem.
// Port A is read-only, port B is read/write with read-first behaviour.
// Both read ports are registered (one-cycle latency). An optional
// post-reset zero-fill walks every line once while init_busy is high.
module block_ram_responder #(
    parameter int ADDR_WIDTH     = 17,
    parameter int RAM_WIDTH      = 128,
    parameter int DEPTH_LOG      = 13,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    output logic [RAM_WIDTH-1:0]  dout_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [RAM_WIDTH-1:0]  din_b,
    input  logic                  we_b,
    output logic [RAM_WIDTH-1:0]  dout_b,
    output logic                  init_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    // One extra bit so the last line is detected by the carry-out
    // instead of by wrapping back to zero.
    logic [DEPTH_LOG:0]   clear_cnt;
    logic [DEPTH_LOG:0]   clear_cnt_next;

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG-1:0] line_a;
    logic [DEPTH_LOG-1:0] line_b;
    logic [DEPTH_LOG-1:0] clear_line;
    logic                 clear_we;
    logic                 user_we;
    logic                 unused_addr_bits;

    // Byte offset and bits above the array size are dropped, so
    // addresses alias modulo the memory size.
    assign line_a     = addr_a[DEPTH_LOG+3:4];
    assign line_b     = addr_b[DEPTH_LOG+3:4];
    assign clear_line = clear_cnt[DEPTH_LOG-1:0];

    assign unused_addr_bits = ^{addr_a, addr_b};

    // Reset and clear both take priority over user writes.
    assign clear_we  = !rst && (state == CLEAR);
    assign user_we   = !rst && (state == IDLE) && we_b;
    assign init_busy = (state == CLEAR);

    // State and clear-counter register; reset picks the start state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clear_cnt <= '0;
        end else begin
            state     <= state_next;
            clear_cnt <= clear_cnt_next;
        end
    end

    // Next-state logic: count through every line, leave CLEAR on carry-out.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next     = state;
        clear_cnt_next = clear_cnt;
        case (state)
            CLEAR: begin
                clear_cnt_next = clear_cnt + (DEPTH_LOG+1)'(1);
                if (clear_cnt_next[DEPTH_LOG]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Array write port: zero-fill during CLEAR, otherwise port B writes.
    always_ff @(posedge clk) begin
        // NOTE: the array itself has no reset so it maps onto block RAM; zero-fill is done by the CLEAR walk.
        if (clear_we) begin
            mem[clear_line] <= '0;
        end else if (user_we) begin
            mem[line_b] <= din_b;
        end
    end

    // Registered read ports; forced to zero during reset and CLEAR.
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            // NOTE: non-blocking reads sample the array before this edge's write lands, giving read-first data.
            dout_a <= mem[line_a];
            dout_b <= mem[line_b];
        end
    end

endmodule

// File: tb/tb_block_ram_responder.sv
// Directed self-checking bench for block_ram_responder.
// dut0: CLEAR_ON_RESET=0 with one spare address bit to exercise aliasing.
// dut1: CLEAR_ON_RESET=1 with default geometry for the zero-fill walk.
module tb_block_ram_responder;

    localparam int W       = 128;
    localparam int LINES   = 8192;
    localparam int BOUND   = 9000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0 signals
    logic          rst0 = 1'b0;
    logic [17:0]   addr_a0 = '0;
    logic [17:0]   addr_b0 = '0;
    logic [W-1:0]  din_b0 = '0;
    logic          we_b0 = 1'b0;
    logic [W-1:0]  dout_a0;
    logic [W-1:0]  dout_b0;
    logic          busy0;

    // dut1 signals
    logic          rst1 = 1'b0;
    logic [16:0]   addr_a1 = '0;
    logic [16:0]   addr_b1 = '0;
    logic [W-1:0]  din_b1 = '0;
    logic          we_b1 = 1'b0;
    logic [W-1:0]  dout_a1;
    logic [W-1:0]  dout_b1;
    logic          busy1;

    int checks   = 0;
    int failures = 0;
    int cycles;

    localparam logic [W-1:0] BEEF = 128'h0123_4567_89AB_CDEF_0000_1111_DEAD_BEEF;

    block_ram_responder #(
        .ADDR_WIDTH(18), .RAM_WIDTH(W), .DEPTH_LOG(13), .CLEAR_ON_RESET(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst0),
        .addr_a(addr_a0), .dout_a(dout_a0),
        .addr_b(addr_b0), .din_b(din_b0), .we_b(we_b0), .dout_b(dout_b0),
        .init_busy(busy0)
    );

    block_ram_responder #(
        .ADDR_WIDTH(17), .RAM_WIDTH(W), .DEPTH_LOG(13), .CLEAR_ON_RESET(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst1),
        .addr_a(addr_a1), .dout_a(dout_a1),
        .addr_b(addr_b1), .din_b(din_b1), .we_b(we_b1), .dout_b(dout_b1),
        .init_busy(busy1)
    );

    // Advance one clock, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Count cycles until dut1 drops init_busy, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy1 === 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
    endtask

    initial begin
        // ---------------- dut0: CLEAR_ON_RESET = 0 ----------------
        rst0 = 1'b1;
        tick();
        tick();
        check("d0_reset_dout_a", dout_a0, '0);
        check("d0_reset_dout_b", dout_b0, '0);
        check("d0_reset_busy", W'(busy0), W'(0));
        rst0 = 1'b0;

        // V-1: write line at 0x00010, read it back on port A.
        addr_b0 = 18'h00010; din_b0 = BEEF; we_b0 = 1'b1;
        tick();
        we_b0 = 1'b0;
        addr_a0 = 18'h00010;
        tick();
        check("v1_read_a", dout_a0, BEEF);
        check("v1_read_b", dout_b0, BEEF);

        // V-2: offset bits and upper aliasing bit ignored.
        addr_a0 = 18'h00013;
        tick();
        check("v2_offset", dout_a0, BEEF);
        addr_a0 = 18'h20010;
        addr_b0 = 18'h2001F;
        tick();
        check("v2_alias_a", dout_a0, BEEF);
        check("v2_alias_b", dout_b0, BEEF);

        // V-3: read-first on both ports during a port B write.
        addr_b0 = 18'h00050; din_b0 = W'(8'h55); we_b0 = 1'b1;
        tick();
        addr_a0 = 18'h00050; addr_b0 = 18'h0005A; din_b0 = W'(8'hAA); we_b0 = 1'b1;
        tick();
        check("v3_old_a", dout_a0, W'(8'h55));
        check("v3_old_b", dout_b0, W'(8'h55));
        we_b0 = 1'b0;
        tick();
        check("v3_new_a", dout_a0, W'(8'hAA));
        check("v3_new_b", dout_b0, W'(8'hAA));

        // V-6: pulse reset with a write attempt; contents survive.
        rst0 = 1'b1;
        addr_b0 = 18'h00010; din_b0 = '1; we_b0 = 1'b1;
        tick();
        check("v6_rst_dout_a", dout_a0, '0);
        check("v6_rst_dout_b", dout_b0, '0);
        check("v6_rst_busy", W'(busy0), W'(0));
        rst0 = 1'b0; we_b0 = 1'b0;
        addr_a0 = 18'h00010; addr_b0 = 18'h00050;
        tick();
        check("v6_keep_a", dout_a0, BEEF);
        check("v6_keep_b", dout_b0, W'(8'hAA));

        // ---------------- dut1: CLEAR_ON_RESET = 1 ----------------
        rst1 = 1'b1;
        tick();
        check("d1_reset_busy", W'(busy1), W'(1));
        check("d1_reset_dout_a", dout_a1, '0);
        rst1 = 1'b0;
        count_busy(cycles);
        check("d1_first_clear_len", W'(cycles), W'(LINES));

        // Preload line 7.
        addr_b1 = 17'h00070; din_b1 = W'(16'h1234); we_b1 = 1'b1;
        tick();
        we_b1 = 1'b0;
        addr_a1 = 17'h00070;
        tick();
        check("v4_preload", dout_a1, W'(16'h1234));

        // V-4: clear with port B hammering line 7 throughout.
        rst1 = 1'b1;
        tick();
        check("v4_rst_busy", W'(busy1), W'(1));
        rst1 = 1'b0;
        addr_b1 = 17'h00070; din_b1 = W'(16'hBEEF); we_b1 = 1'b1;
        tick();
        check("v4_clear_dout_a", dout_a1, '0);
        check("v4_clear_dout_b", dout_b1, '0);
        count_busy(cycles);
        check("v4_clear_len", W'(cycles + 1), W'(LINES));
        we_b1 = 1'b0;
        tick();
        check("v4_line7_a", dout_a1, '0);
        check("v4_line7_b", dout_b1, '0);

        // V-5: interrupt the clear at count 100, it restarts from zero.
        addr_b1 = 17'h00100; din_b1 = W'(8'h77); we_b1 = 1'b1;
        tick();
        we_b1 = 1'b0;
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            if (i == 100) break;
            tick();
        end
        check("v5_busy_at_100", W'(busy1), W'(1));
        rst1 = 1'b1;
        tick();
        check("v5_rst_busy", W'(busy1), W'(1));
        rst1 = 1'b0;
        count_busy(cycles);
        check("v5_restart_len", W'(cycles), W'(LINES));
        addr_a1 = 17'h00100;
        tick();
        check("v5_line16_cleared", dout_a1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_ram_responder.md
BLOCK_RAM_RESPONDER -- requirements
Module: block_ram_responder

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset.
- REQ-002: Parameter ADDR_WIDTH, default 17: byte address width, matching the CPU memory ports.
- REQ-003: Parameter RAM_WIDTH, default 128: line width in bits (16 bytes per line).
- REQ-004: Parameter DEPTH_LOG, default 13: log2 of the line count (8192 lines = 128 KB).
- REQ-005: Parameter CLEAR_ON_RESET, default 0: 1 selects zero-fill of every line after reset.
- REQ-006: Port clk, input, 1: rising-edge clock.
- REQ-007: Port rst, input, 1: synchronous active-high reset.
- REQ-008: Port addr_a, input, ADDR_WIDTH: port A byte address (read-only port).
- REQ-009: Port dout_a, output, RAM_WIDTH: port A read line.
- REQ-010: Port addr_b, input, ADDR_WIDTH: port B byte address.
- REQ-011: Port din_b, input, RAM_WIDTH: port B write line.
- REQ-012: Port we_b, input, 1: port B write enable.
- REQ-013: Port dout_b, output, RAM_WIDTH: port B read line.
- REQ-014: Port init_busy, output, 1: high while the zero-fill is in progress.

Function
- REQ-015: The line index SHALL be addr[DEPTH_LOG+3:4]; addr[3:0] SHALL be ignored, and bits above DEPTH_LOG+3 SHALL be ignored (address wraps modulo the memory size).
- REQ-016: Reads SHALL have 1-cycle latency: dout_x after edge N SHALL equal the line at addr_x sampled at edge N, and SHALL hold until the next edge.
- REQ-017: Port A SHALL read on every cycle; port B SHALL read on every cycle, including cycles with a write.
- REQ-018: A port B write SHALL commit din_b to the line at addr_b on the edge where we_b=1, with no wait states.
- REQ-019: When port B writes and reads the same line in one cycle, dout_b SHALL return the old data (read-first).
- REQ-020: When port A reads the line that port B writes in the same cycle, dout_a SHALL return the old data.
- REQ-021: The block SHALL implement a state machine with states IDLE and CLEAR.
- REQ-022: While rst=1, the state SHALL be CLEAR if CLEAR_ON_RESET=1 and IDLE otherwise, and the clear counter SHALL be 0.
- REQ-023: In CLEAR, the block SHALL write zero to line counter on each edge and increment the counter by 1.
- REQ-024: After the edge that writes line 2^DEPTH_LOG-1, the block SHALL enter IDLE; the counter width is DEPTH_LOG+1 so that the terminal count is detected without wrapping.
- REQ-025: init_busy SHALL be 1 exactly while the state is CLEAR.
- REQ-026: In CLEAR, we_b SHALL be ignored, and dout_a and dout_b SHALL be driven to 0.
- REQ-027: If rst is asserted mid-clear, the clear SHALL restart from line 0 once rst deasserts.
- REQ-028: With CLEAR_ON_RESET=0, memory contents SHALL be unaffected by reset.

Reset
- REQ-029: While rst=1, dout_a and dout_b SHALL be 0 on the next edge, and port B writes SHALL be ignored.
- REQ-030: While rst=1, init_busy SHALL be 1 if CLEAR_ON_RESET=1 and 0 otherwise.

Verification
- V-1: Write line 0x00010 = 0x...DEADBEEF, then read port A at addr 0x00010 -> dout_a = 0x...DEADBEEF one cycle later.
- V-2: Read at addr 0x00013 -> same data as at 0x00010 (offset bits ignored); addr 0x20010 aliases to 0x00010.
- V-3: Write 0xAA to line 5 while port A and port B both read line 5 (old value 0x55) -> both outputs return 0x55 that cycle and 0xAA on the next read.
- V-4: CLEAR_ON_RESET=1, line 7 preloaded with 0x1234, release rst -> init_busy stays high for exactly 8192 cycles; writes during CLEAR are dropped; line 7 then reads 0.
- V-5: Assert rst at clear count 100, release it -> the clear restarts at 0 and init_busy stays high for a further 8192 cycles.
- V-6: CLEAR_ON_RESET=0, pulse rst -> outputs are 0 during reset; previously written lines read back unchanged afterwards.
